// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: per-FU round-robin pick of ready RS entries into issue slots.
// Optional macro RS_ISSUE_STATS_EN adds per-FU issue/stall counters.
module rs_issue_scheduler #(
   parameter int NUM_RS    = 5,
   parameter int NUM_FU    = 3,
   parameter int ROB_TAG_W = 5,
   parameter int IDX_W     = $clog2(NUM_RS)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_RS-1:0]             rs_ready,
   input  logic [NUM_RS*2-1:0]           rs_fu_type,
   input  logic [NUM_RS*ROB_TAG_W-1:0]   rs_rob_tag,
   input  logic [NUM_FU-1:0]             fu_ready,
   input  logic                          flush,
   output logic [NUM_RS-1:0]             rs_grant,
   output logic [NUM_FU-1:0]             issue_valid,
   output logic [NUM_FU*IDX_W-1:0]       issue_rs_idx,
   output logic [NUM_FU*ROB_TAG_W-1:0]   issue_rob_tag
`ifdef RS_ISSUE_STATS_EN
   ,
   output logic [NUM_FU*16-1:0]          issue_count,
   output logic [NUM_FU*16-1:0]          stall_count
`endif
);

   typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} slot_state_t;

   logic [NUM_RS-1:0]              r_grant_mask;
   logic [NUM_FU-1:0][NUM_RS-1:0]  w_grant_oh;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
         slot_state_t            r_state;
         logic [IDX_W-1:0]       r_rr_ptr;
         logic [IDX_W-1:0]       r_idx;
         logic [ROB_TAG_W-1:0]   r_tag;
         logic [NUM_RS-1:0]      w_cand;
         logic [IDX_W:0]         w_pos;
         logic [IDX_W-1:0]       w_sel;
         logic [ROB_TAG_W-1:0]   w_tag_sel;
         logic                   w_found;
         logic                   w_accept;
         logic                   w_grant;

         always_comb begin
            w_cand = '0;
            for (int i = 0; i < NUM_RS; i++)
               w_cand[i] = rs_ready[i] && (rs_fu_type[2*i +: 2] == 2'(gi)) && !r_grant_mask[i];
         end

         // Walk upward from the pointer with wrap; first candidate wins.
         always_comb begin
            w_found = 1'b0;
            w_sel   = '0;
            w_pos   = '0;
            for (int k = 0; k < NUM_RS; k++) begin
               w_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
               if (w_pos >= (IDX_W+1)'(NUM_RS))
                  w_pos = w_pos - (IDX_W+1)'(NUM_RS);
               if (!w_found && w_cand[w_pos[IDX_W-1:0]]) begin
                  w_found = 1'b1;
                  w_sel   = w_pos[IDX_W-1:0];
               end
            end
         end

         always_comb begin
            w_tag_sel = '0;
            for (int i = 0; i < NUM_RS; i++)
               if (w_sel == IDX_W'(i))
                  w_tag_sel = rs_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
         end

         assign w_accept       = (r_state == S_EMPTY) || fu_ready[gi];
         assign w_grant        = w_found && w_accept && !flush && reset;
         assign w_grant_oh[gi] = w_grant ? (NUM_RS'(1) << w_sel) : '0;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_state  <= S_EMPTY;
               r_idx    <= '0;
               r_tag    <= '0;
               r_rr_ptr <= '0;
            end else if (flush) begin
               r_state  <= S_EMPTY;
               r_rr_ptr <= '0;
            end else begin
               case (r_state)
                  S_EMPTY: begin
                     if (w_grant) begin
                        r_state <= S_HELD;
                        r_idx   <= w_sel;
                        r_tag   <= w_tag_sel;
                     end
                  end
                  S_HELD: begin
                     if (fu_ready[gi]) begin
                        if (w_grant) begin
                           r_idx <= w_sel;
                           r_tag <= w_tag_sel;
                        end else begin
                           r_state <= S_EMPTY;
                        end
                     end
                  end
               endcase
               if (w_grant)
                  r_rr_ptr <= (w_sel == IDX_W'(NUM_RS-1)) ? '0 : w_sel + 1'b1;
            end
         end

         assign issue_valid[gi]                          = (r_state == S_HELD);
         assign issue_rs_idx[gi*IDX_W +: IDX_W]          = r_idx;
         assign issue_rob_tag[gi*ROB_TAG_W +: ROB_TAG_W] = r_tag;

`ifdef RS_ISSUE_STATS_EN
         logic [15:0] r_issue_cnt;
         logic [15:0] r_stall_cnt;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_issue_cnt <= '0;
               r_stall_cnt <= '0;
            end else begin
               if (issue_valid[gi] && fu_ready[gi] && (r_issue_cnt != 16'hFFFF))
                  r_issue_cnt <= r_issue_cnt + 16'd1;
               if (issue_valid[gi] && !fu_ready[gi] && (r_stall_cnt != 16'hFFFF))
                  r_stall_cnt <= r_stall_cnt + 16'd1;
            end
         end

         assign issue_count[gi*16 +: 16] = r_issue_cnt;
         assign stall_count[gi*16 +: 16] = r_stall_cnt;
`endif
      end
   endgenerate

   always_comb begin
      rs_grant = '0;
      for (int f = 0; f < NUM_FU; f++)
         rs_grant = rs_grant | w_grant_oh[f];
   end

   // The RS drops rs_ready one cycle late, so last cycle's grants are masked.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_grant_mask <= '0;
      else if (flush)
         r_grant_mask <= '0;
      else
         r_grant_mask <= rs_grant;
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: scoreboard bench for rs_issue_scheduler with directed
// scenarios (idle, single issue, round-robin, backpressure, parallel, flush, reset) and random traffic.
module tb_rs_issue_scheduler;
   localparam int NUM_RS    = 5;
   localparam int NUM_FU    = 3;
   localparam int ROB_TAG_W = 5;
   localparam int IDX_W     = $clog2(NUM_RS);

   logic                          clock;
   logic                          reset;
   logic [NUM_RS-1:0]             rs_ready;
   logic [NUM_RS*2-1:0]           rs_fu_type;
   logic [NUM_RS*ROB_TAG_W-1:0]   rs_rob_tag;
   logic [NUM_FU-1:0]             fu_ready;
   logic                          flush;
   logic [NUM_RS-1:0]             rs_grant;
   logic [NUM_FU-1:0]             issue_valid;
   logic [NUM_FU*IDX_W-1:0]       issue_rs_idx;
   logic [NUM_FU*ROB_TAG_W-1:0]   issue_rob_tag;

   rs_issue_scheduler #(
      .NUM_RS(NUM_RS), .NUM_FU(NUM_FU), .ROB_TAG_W(ROB_TAG_W), .IDX_W(IDX_W)
   ) dut (
      .clock(clock), .reset(reset), .rs_ready(rs_ready), .rs_fu_type(rs_fu_type),
      .rs_rob_tag(rs_rob_tag), .fu_ready(fu_ready), .flush(flush), .rs_grant(rs_grant),
      .issue_valid(issue_valid), .issue_rs_idx(issue_rs_idx), .issue_rob_tag(issue_rob_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [NUM_RS-1:0]           grant;
      logic [NUM_FU-1:0]           valid;
      logic [NUM_FU*IDX_W-1:0]     idx;
      logic [NUM_FU*ROB_TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference state of the scheduler
   logic [NUM_FU-1:0]    m_valid;
   logic [IDX_W-1:0]     m_idx[NUM_FU];
   logic [ROB_TAG_W-1:0] m_tag[NUM_FU];
   int                   m_ptr[NUM_FU];
   int                   m_sel[NUM_FU];
   logic [NUM_FU-1:0]    m_found;
   logic [NUM_RS-1:0]    m_mask;
   logic [NUM_RS-1:0]    m_grant;

   // Values sampled from the DUT in the last transaction
   logic [NUM_RS-1:0]           l_grant;
   logic [NUM_FU-1:0]           l_valid;
   logic [NUM_FU*IDX_W-1:0]     l_idx;
   logic [NUM_FU*ROB_TAG_W-1:0] l_tag;

   logic [NUM_RS-1:0] rr_rdy[4];
   logic [NUM_RS-1:0] rr_exp[4];
   logic [NUM_RS-1:0] rr_got[4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_entry(input int i, input logic [1:0] t, input logic [ROB_TAG_W-1:0] tg);
      rs_fu_type[2*i +: 2]               = t;
      rs_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] = tg;
   endtask

   task automatic model_reset();
      m_valid = '0;
      m_mask  = '0;
      m_grant = '0;
      m_found = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         m_idx[f] = '0;
         m_tag[f] = '0;
         m_ptr[f] = 0;
         m_sel[f] = 0;
      end
   endtask

   task automatic model_eval();
      int p;
      m_grant = '0;
      m_found = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         m_sel[f] = 0;
         if (!flush && (!m_valid[f] || fu_ready[f])) begin
            for (int k = 0; k < NUM_RS; k++) begin
               p = (m_ptr[f] + k) % NUM_RS;
               if (!m_found[f] && rs_ready[p] && !m_mask[p] && (int'(rs_fu_type[2*p +: 2]) == f)) begin
                  m_found[f] = 1'b1;
                  m_sel[f]   = p;
                  m_grant[p] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic model_update();
      if (flush) begin
         m_valid = '0;
         m_mask  = '0;
         for (int f = 0; f < NUM_FU; f++) m_ptr[f] = 0;
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            if (m_found[f]) begin
               m_valid[f] = 1'b1;
               m_idx[f]   = IDX_W'(m_sel[f]);
               m_tag[f]   = rs_rob_tag[m_sel[f]*ROB_TAG_W +: ROB_TAG_W];
               m_ptr[f]   = (m_sel[f] + 1) % NUM_RS;
            end else if (fu_ready[f]) begin
               m_valid[f] = 1'b0;
            end
         end
         m_mask = m_grant;
      end
   endtask

   task automatic compare_outputs();
      exp_t e;
      e = exp_q.pop_front();
      l_grant = rs_grant;
      l_valid = issue_valid;
      l_idx   = issue_rs_idx;
      l_tag   = issue_rob_tag;
      $display("t=%0t rdy=%b fu_rdy=%b flush=%b grant=%b valid=%b idx=%h tag=%h",
               $time, rs_ready, fu_ready, flush, rs_grant, issue_valid, issue_rs_idx, issue_rob_tag);
      check("sb_grant", rs_grant, e.grant);
      check("sb_valid", issue_valid, e.valid);
      for (int f = 0; f < NUM_FU; f++) begin
         if (e.valid[f]) begin
            check("sb_idx", issue_rs_idx[f*IDX_W +: IDX_W], e.idx[f*IDX_W +: IDX_W]);
            check("sb_tag", issue_rob_tag[f*ROB_TAG_W +: ROB_TAG_W], e.tag[f*ROB_TAG_W +: ROB_TAG_W]);
         end
      end
   endtask

   // One transaction: entered and left at posedge+1.
   task automatic do_cycle(input logic [NUM_RS-1:0] rdy, input logic [NUM_FU-1:0] fr, input logic fl);
      exp_t e;
      rs_ready = rdy;
      fu_ready = fr;
      flush    = fl;
      model_eval();
      e.grant = m_grant;
      e.valid = m_valid;
      for (int f = 0; f < NUM_FU; f++) begin
         e.idx[f*IDX_W +: IDX_W]         = m_idx[f];
         e.tag[f*ROB_TAG_W +: ROB_TAG_W] = m_tag[f];
      end
      exp_q.push_back(e);
      @(negedge clock);
      compare_outputs();
      @(posedge clock);
      #1;
      model_update();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      rs_ready   = '1;
      rs_fu_type = '0;
      rs_rob_tag = '0;
      fu_ready   = '1;
      flush      = 1'b0;
      model_reset();

      // Reset: everything held at zero even with ready entries present
      repeat (2) begin
         @(negedge clock);
         check("rst_grant", rs_grant, 0);
         check("rst_valid", issue_valid, 0);
         check("rst_idx", issue_rs_idx, 0);
         check("rst_tag", issue_rob_tag, 0);
      end
      @(posedge clock);
      #1;
      reset    = 1'b1;
      rs_ready = '0;

      repeat (3) begin
         do_cycle('0, 3'b111, 1'b0);
         check("idle_grant", l_grant, 0);
         check("idle_valid", l_valid, 0);
      end

      // Single ALU issue
      set_entry(0, 2'd0, 5'd7);
      do_cycle(5'b00001, 3'b111, 1'b0);
      check("alu_grant", l_grant, 5'b00001);
      do_cycle(5'b00001, 3'b111, 1'b0);
      check("alu_no_regrant", l_grant, 0);
      check("alu_valid", l_valid[0], 1);
      check("alu_idx", l_idx[IDX_W-1:0], 0);
      check("alu_tag", l_tag[ROB_TAG_W-1:0], 7);
      do_cycle('0, 3'b111, 1'b0);
      do_cycle('0, 3'b111, 1'b1);

      // Round-robin over entries 0,2,4; entries 1,3 have a class that never issues
      set_entry(0, 2'd0, 5'd1);
      set_entry(1, 2'd3, 5'd2);
      set_entry(2, 2'd0, 5'd3);
      set_entry(3, 2'd3, 5'd4);
      set_entry(4, 2'd0, 5'd5);
      rr_rdy[0] = 5'b11111; rr_rdy[1] = 5'b11110; rr_rdy[2] = 5'b11011; rr_rdy[3] = 5'b01111;
      rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b10000; rr_exp[3] = 5'b00001;
      for (int c = 0; c < 4; c++) begin
         do_cycle(rr_rdy[c], 3'b111, 1'b0);
         rr_got[c] = l_grant;
      end
      for (int c = 0; c < 4; c++) check("rr_order", rr_got[c], rr_exp[c]);
      do_cycle('0, 3'b111, 1'b0);
      do_cycle('0, 3'b111, 1'b0);

      // Backpressure on the LoadStore slot
      set_entry(0, 2'd3, 5'd0);
      set_entry(1, 2'd1, 5'd9);
      set_entry(2, 2'd1, 5'd3);
      set_entry(4, 2'd3, 5'd0);
      do_cycle(5'b00100, 3'b111, 1'b0);
      check("bp_first_grant", l_grant, 5'b00100);
      repeat (4) begin
         do_cycle(5'b00010, 3'b101, 1'b0);
         check("bp_no_grant", l_grant, 0);
         check("bp_held_valid", l_valid[1], 1);
         check("bp_held_tag", l_tag[2*ROB_TAG_W-1:ROB_TAG_W], 3);
      end
      do_cycle(5'b00010, 3'b111, 1'b0);
      check("bp_release_grant", l_grant, 5'b00010);
      do_cycle('0, 3'b111, 1'b0);
      check("bp_new_tag", l_tag[2*ROB_TAG_W-1:ROB_TAG_W], 9);
      do_cycle('0, 3'b111, 1'b0);

      // All three FU classes in one cycle
      set_entry(0, 2'd0, 5'd11);
      set_entry(1, 2'd1, 5'd12);
      set_entry(2, 2'd3, 5'd13);
      set_entry(3, 2'd2, 5'd14);
      set_entry(4, 2'd3, 5'd15);
      do_cycle(5'b01011, 3'b111, 1'b0);
      check("par_grant", l_grant, 5'b01011);
      do_cycle('0, 3'b010, 1'b0);
      check("par_valid", l_valid, 3'b111);

      // Flush with slots 0 and 2 held; afterwards FU0 restarts from index 0
      set_entry(4, 2'd0, 5'd16);
      do_cycle(5'b11111, 3'b111, 1'b1);
      check("flush_grant", l_grant, 0);
      check("flush_pre_valid", l_valid, 3'b101);
      do_cycle(5'b11111, 3'b111, 1'b0);
      check("flush_post_valid", l_valid, 0);
      check("flush_lowest", l_grant, 5'b01011);
      do_cycle('0, 3'b111, 1'b0);
      do_cycle('0, 3'b111, 1'b0);

      // Reset in the middle of a held slot
      do_cycle(5'b00001, 3'b000, 1'b0);
      rs_ready = 5'b11111;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_valid", issue_valid, 0);
      check("midrst_tag", issue_rob_tag, 0);
      check("midrst_grant", rs_grant, 0);
      model_reset();
      @(posedge clock);
      #1;
      reset    = 1'b1;
      rs_ready = '0;
      do_cycle('0, 3'b111, 1'b0);

      // Random traffic against the reference model
      for (int n = 0; n < 80; n++) begin
         if (n % 10 == 0) begin
            for (int i = 0; i < NUM_RS; i++)
               set_entry(i, 2'($urandom_range(0, 3)), ROB_TAG_W'($urandom));
         end
         do_cycle(NUM_RS'($urandom), NUM_FU'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Sits between the reservation station and the functional units.
- Each cycle, for every FU class, picks one ready RS entry using per-FU round-robin and loads it into a per-FU issue slot register.
- Tells the RS which entries were granted so they can be marked issued.
- Presents each slot to its FU with a valid/ready handshake; flushes on branch mispredict.

Parameters:
- NUM_RS, 5, number of RS entries (indices 0..NUM_RS-1).
- NUM_FU, 3, number of FU classes (0=ALU, 1=LoadStore, 2=FloatingPoint).
- ROB_TAG_W, 5, width of a ROB tag.
- IDX_W, $clog2(NUM_RS), width of an RS index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- rs_ready  in  NUM_RS  entry i is busy, has both operands valid, and is not yet issued.
- rs_fu_type  in  NUM_RS*2  entry i FU class at bits [2i+1:2i]; values >= NUM_FU never issue.
- rs_rob_tag  in  NUM_RS*ROB_TAG_W  ROB tag of entry i.
- fu_ready  in  NUM_FU  FU f accepts its slot this cycle.
- flush  in  1  synchronous squash of all in-flight scheduling state.
- rs_grant  out  NUM_RS  one-cycle pulse; entry i was moved into an issue slot.
- issue_valid  out  NUM_FU  slot f holds an instruction for FU f.
- issue_rs_idx  out  NUM_FU*IDX_W  RS index held in slot f.
- issue_rob_tag  out  NUM_FU*ROB_TAG_W  ROB tag held in slot f.

Behaviour:
- Reset (reset==0, asynchronous): all of the following are 0 and stay 0 until reset deasserts:
  - issue_valid, issue_rs_idx, issue_rob_tag, rs_grant
  - rr_ptr[f] for all f
  - grant_mask
- Per-FU slot FSM, two states:
  - EMPTY: issue_valid[f]=0.
  - HELD: issue_valid[f]=1.
  - EMPTY->HELD when a candidate is granted.
  - HELD->EMPTY on fu_ready[f] with no new grant.
  - HELD->HELD on fu_ready[f] with a new grant (back-to-back issue, no bubble).
  - HELD with fu_ready[f]=0: slot contents are frozen.
- Slot f can accept a grant iff !issue_valid[f] || fu_ready[f].
- Candidate for FU f: rs_ready[i] && rs_fu_type[i]==f && !grant_mask[i].
- Round-robin selection per FU:
  - Search from rr_ptr[f] upward, wrapping from NUM_RS-1 to 0.
  - First candidate found wins.
  - On a grant of entry i: rr_ptr[f] <= (i+1 == NUM_RS) ? 0 : i+1.
  - With no grant, rr_ptr[f] is unchanged.
- Latency: a grant decided in cycle N drives rs_grant[i] combinationally in cycle N. The slot registers update at edge N+1, so issue_valid is visible in cycle N+1.
- grant_mask <= rs_grant. This masks entry i in cycle N+1, because the RS clears rs_ready one cycle after a grant. Prevents double issue.
- At most one grant per FU per cycle; up to NUM_FU grants total. An entry maps to one FU class, so grants never conflict.
- Empty candidate set: no grant; slot follows the FSM above.
- All entries ready for the same FU: exactly one granted per cycle, in rotating order.
- flush==1 (takes priority over everything except reset):
  - rs_grant is forced to 0 that cycle.
  - At the next edge: issue_valid, grant_mask and rr_ptr are cleared to 0.
  - fu_ready that same cycle is ignored; the slot is dropped, not handed over.
- Reset asserted mid-handshake: the slot is discarded immediately, with no partial output.

Optional Feature:
- Macro: RS_ISSUE_STATS_EN.
- When defined, adds output issue_count (NUM_FU*16 bits) and output stall_count (NUM_FU*16 bits).
  - issue_count[f] increments on each fu_ready[f]&&issue_valid[f].
  - stall_count[f] increments on each issue_valid[f]&&!fu_ready[f].
  - Both saturate at 16'hFFFF.
  - Both clear on reset; they do not clear on flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with rs_ready=0 -> issue_valid=000, rs_grant=00000 every cycle.
- Single ALU issue:
  - Stimulus: rs_ready=00001, type0=0, tag0=5'd7, fu_ready=111.
  - Cycle N: rs_grant=00001.
  - Cycle N+1: issue_valid[0]=1, issue_rs_idx[0]=0, issue_rob_tag[0]=7.
  - Entry 0 is not regranted in N+1 even though rs_ready is still 1.
- Round-robin fairness: entries 0, 2, 4 all type 0, held ready, RS drops each entry 1 cycle after its grant and re-raises it 1 cycle later -> grant order is 0, 2, 4, 0.
- Backpressure:
  - Slot 1 HELD with tag 3, fu_ready[1]=0 for 4 cycles, entry 1 (type 1) ready -> slot holds tag 3 and no grant to entry 1.
  - fu_ready[1]=1 -> entry 1 granted in that same cycle; next cycle issue_rob_tag[1] = entry 1's tag.
- Parallel FUs: entries 0, 1, 3 of types 0, 1, 2, all ready -> rs_grant=01011 in one cycle; all three slots valid the next cycle.
- Flush: slots 0 and 2 HELD, flush=1 with fu_ready=111 and entries ready -> rs_grant=0 that cycle; next cycle issue_valid=000 and rr_ptr=0 (the next grant selects the lowest ready index).
